// File: rtl/lcd_message_writer.sv
// Streams an NCHAR-character message to the LCD byte FSM as HD44780 bytes:
// optional clear, home, the characters, and a DDRAM jump to line 2 after COLS.
module lcd_message_writer #(
  parameter int          NCHAR      = 16,
  parameter int          COLS       = 8,
  parameter logic [7:0]  LINE2_ADDR = 8'h40,
  parameter int          USE_CLEAR  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_msg,
  input  logic [8*NCHAR-1:0]   msg,
  input  logic                 byte_ready,
  output logic                 byte_valid,
  output logic [7:0]           byte_d,
  output logic                 byte_rs,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int IW = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHAR - 1);
  localparam bit HAS_LINE2 = (NCHAR > COLS);
  // Only meaningful when the message spills onto line 2; otherwise COLS-1 may not fit in idx.
  localparam logic [IW-1:0] COL_END = HAS_LINE2 ? IW'(COLS - 1) : '0;

  typedef enum logic [2:0] {IDLE, CLEAR, HOME, CHAR, LINE2} state_t;
  localparam state_t START = (USE_CLEAR != 0) ? CLEAR : HOME;

  state_t                 state, state_n;
  logic [IW-1:0]          idx, idx_n;
  logic [NCHAR-1:0][7:0]  act_buf, act_n, pend_buf, pend_n;
  logic                   pending, pending_n;
  logic [7:0]             byte_n;
  logic                   xfer, last_xfer;

  assign xfer      = byte_valid & byte_ready;
  assign last_xfer = xfer && (state == CHAR) && (idx == LAST_IDX);
  assign done      = last_xfer;
  assign overrun   = new_msg && (state != IDLE) && pending;

  // Next-state logic; the byte outputs are registered from these next values.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    act_n     = act_buf;
    pend_n    = pend_buf;
    pending_n = pending;
    byte_n    = 8'h00;

    case (state)
      IDLE: begin
        if (new_msg) begin
          act_n   = msg;
          idx_n   = '0;
          state_n = START;
        end
      end
      CLEAR: if (xfer) state_n = HOME;
      HOME:  if (xfer) state_n = CHAR;
      CHAR: begin
        if (xfer && (idx != LAST_IDX)) begin
          idx_n = idx + 1'b1;
          if (HAS_LINE2 && (idx == COL_END)) state_n = LINE2;
        end
      end
      LINE2: if (xfer) state_n = CHAR;
      default: state_n = IDLE;
    endcase

    if ((state != IDLE) && new_msg) begin
      pend_n    = msg;
      pending_n = 1'b1;
    end

    // Back-to-back messages chain straight into the next header with no idle cycle.
    if (last_xfer) begin
      if (new_msg || pending) begin
        act_n     = new_msg ? msg : pend_buf;
        pending_n = 1'b0;
        idx_n     = '0;
        state_n   = START;
      end else begin
        state_n = IDLE;
      end
    end

    case (state_n)
      CLEAR:   byte_n = 8'h01;
      HOME:    byte_n = 8'h02;
      CHAR:    byte_n = act_n[idx_n];
      LINE2:   byte_n = 8'h80 | LINE2_ADDR;
      default: byte_n = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      act_buf    <= '0;
      pend_buf   <= '0;
      pending    <= 1'b0;
      byte_valid <= 1'b0;
      byte_d     <= 8'h00;
      byte_rs    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      act_buf    <= act_n;
      pend_buf   <= pend_n;
      pending    <= pending_n;
      byte_valid <= (state_n != IDLE);
      byte_d     <= byte_n;
      byte_rs    <= (state_n == CHAR);
      busy       <= (state_n != IDLE);
    end
  end

endmodule
